// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared register-file types and constants for the writeback path
//
// Purpose: architectural constants and the writeback request record used by
// rf_writeback and its LSU result FIFO.
//   XLEN      data width
//   NREG      architectural register count (x0 hardwired zero)
//   REG_AW    register index width
//   reg_idx_t register index
//   wb_req_t  {rd, data} writeback request
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of writeback requests for LSU load results
//
// Purpose: holds LSU load results until the write port is free.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointers/count only)
//   push        write push_data (ignored while full)
//   push_data   request to enqueue
//   pop         drop the head entry (ignored while empty)
//   head        oldest entry, valid while !empty
//   full        DEPTH entries held
//   empty       no entries held
//   count       number of entries held
module wb_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// rtl/rf_writeback.sv - register-file write port arbiter, load scoreboard and operand bypass
//
// Purpose: sole driver of the regfile we3/wa3/wd3 port. ALU results win the
// port; queued LSU load data is written when the ALU is idle. A busy vector
// tracks registers with loads in flight so decode can stall.
// Build option: define WB_BYPASS_EN to forward the registered write to the
// EX operands; without it operands pass straight through and stall also
// covers a source matching the pending write.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data    ALU result (never back-pressured)
//   ld_issue/ld_rd               load issue, marks ld_rd busy
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  LSU load result handshake
//   rf_we/rf_wa/rf_wd            registered regfile write port
//   chk_ra1/chk_ra2/chk_rd       decode operand/destination indices
//   stall                        decode hazard stall
//   busy                         scoreboard vector
//   rf_rd1/rf_rd2                regfile read data
//   byp_rd1/byp_rd2              operands to EX
module rf_writeback
    import rv_pkg::*;
#(
    parameter int LSU_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_issue,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [XLEN-1:0]   rf_wd,
    input  logic [REG_AW-1:0] chk_ra1,
    input  logic [REG_AW-1:0] chk_ra2,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              stall,
    output logic [NREG-1:0]   busy,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    output logic [XLEN-1:0]   byp_rd1,
    output logic [XLEN-1:0]   byp_rd2
);

    // Occupancy is kept for debug visibility; full/empty drive the control.
    logic [$clog2(LSU_DEPTH):0] fifo_level_unused;
    logic                       fifo_full;
    logic                       fifo_empty;
    wb_req_t                    fifo_head;
    wb_req_t                    fifo_in;
    logic                       fifo_push;
    logic                       fifo_pop;

    logic                       ready_en;
    logic                       alu_win;
    logic [NREG-1:0]            busy_set;
    logic [NREG-1:0]            busy_clr;
    logic                       sb_hit;
    logic                       fwd1;
    logic                       fwd2;

    // lsu_ready stays low through reset and the cycle of release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    assign lsu_ready = ready_en && !fifo_full;
    assign fifo_push = lsu_valid && lsu_ready;
    assign fifo_in   = '{rd: lsu_rd, data: lsu_data};

    // An ALU write to x0 does not claim the port, so the FIFO may drain then.
    assign alu_win  = alu_valid && (alu_rd != '0);
    assign fifo_pop = !alu_win && !fifo_empty;

    wb_fifo #(
        .DEPTH (LSU_DEPTH)
    ) u_lsu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_level_unused)
    );

    // Write port register. A popped x0 load still leaves the FIFO but emits no write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (alu_win) begin
            rf_we <= 1'b1;
            rf_wa <= alu_rd;
            rf_wd <= alu_data;
        end else if (!fifo_empty) begin
            rf_we <= (fifo_head.rd != '0);
            rf_wa <= fifo_head.rd;
            rf_wd <= fifo_head.data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (ld_issue && (ld_rd != '0)) begin
            busy_set[ld_rd] = 1'b1;
        end
        if (fifo_pop && (fifo_head.rd != '0)) begin
            busy_clr[fifo_head.rd] = 1'b1;
        end
    end

    // Set is applied after clear so a same-edge issue to the popped rd stays busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
        end
    end

    assign sb_hit = busy[chk_ra1] | busy[chk_ra2] | busy[chk_rd];
    assign fwd1   = rf_we && (rf_wa == chk_ra1) && (chk_ra1 != '0);
    assign fwd2   = rf_we && (rf_wa == chk_ra2) && (chk_ra2 != '0);

`ifdef WB_BYPASS_EN
    assign byp_rd1 = fwd1 ? rf_wd : rf_rd1;
    assign byp_rd2 = fwd2 ? rf_wd : rf_rd2;
    assign stall   = sb_hit;
`else
    // No forwarding path: a source matching the uncommitted write must wait a cycle.
    assign byp_rd1 = rf_rd1;
    assign byp_rd2 = rf_rd2;
    assign stall   = sb_hit | fwd1 | fwd2;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// tb/tb_rf_writeback.sv - self-checking bench for rf_writeback against a queue-based model
module tb_rf_writeback;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  chk_ra1;
    logic [4:0]  chk_ra2;
    logic [4:0]  chk_rd;
    logic        stall;
    logic [31:0] busy;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [31:0] byp_rd1;
    logic [31:0] byp_rd2;

    rf_writeback #(.LSU_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_issue  (ld_issue),
        .ld_rd     (ld_rd),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .chk_ra1   (chk_ra1),
        .chk_ra2   (chk_ra2),
        .chk_rd    (chk_rd),
        .stall     (stall),
        .busy      (busy),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .byp_rd1   (byp_rd1),
        .byp_rd2   (byp_rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: expected write port, queued loads, busy set, ready gate.
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] m_busy;
    logic        m_ready_en;
    logic        m_acc;
    ent_t        mq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_we = 1'b0;
        e_wa = '0;
        e_wd = '0;
        m_busy = '0;
        m_ready_en = 1'b0;
        m_acc = 1'b0;
        mq.delete();
    endtask

    function automatic logic pend_hit(input logic [4:0] ra);
        return e_we && (e_wa == ra) && (ra != 5'd0);
    endfunction

    function automatic logic exp_stall();
        logic s;
        s = m_busy[chk_ra1] | m_busy[chk_ra2] | m_busy[chk_rd];
`ifndef WB_BYPASS_EN
        s = s | pend_hit(chk_ra1) | pend_hit(chk_ra2);
`endif
        return s;
    endfunction

    function automatic logic [31:0] exp_byp(input logic [4:0] ra, input logic [31:0] rd_val);
`ifdef WB_BYPASS_EN
        return pend_hit(ra) ? e_wd : rd_val;
`else
        return rd_val;
`endif
    endfunction

    task automatic check_all();
        check("rf_we", {31'd0, rf_we}, {31'd0, e_we});
        check("rf_wa", {27'd0, rf_wa}, {27'd0, e_wa});
        check("rf_wd", rf_wd, e_wd);
        check("busy", busy, m_busy);
        check("lsu_ready", {31'd0, lsu_ready}, {31'd0, m_ready_en && (mq.size() < DEPTH)});
        check("stall", {31'd0, stall}, {31'd0, exp_stall()});
        check("byp_rd1", byp_rd1, exp_byp(chk_ra1, rf_rd1));
        check("byp_rd2", byp_rd2, exp_byp(chk_ra2, rf_rd2));
    endtask

    // Advance the model by one edge from the inputs presented now, then compare.
    task automatic tick();
        ent_t h;
        m_acc = lsu_valid && m_ready_en && (mq.size() < DEPTH);
        if (alu_valid && alu_rd != 5'd0) begin
            e_we = 1'b1;
            e_wa = alu_rd;
            e_wd = alu_data;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            e_we = (h.rd != 5'd0);
            e_wa = h.rd;
            e_wd = h.data;
            m_busy[h.rd] = 1'b0;
        end else begin
            e_we = 1'b0;
        end
        if (ld_issue && ld_rd != 5'd0) m_busy[ld_rd] = 1'b1;
        if (m_acc) mq.push_back(ent_t'{rd: lsu_rd, data: lsu_data});
        m_ready_en = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    logic [4:0]  pending[$];
    logic        cur_valid;
    logic [4:0]  cur_rd;
    logic [31:0] cur_data;
    logic [31:0] d4 [3];
    int          idx;
    int          accepted_in_alu;

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue = 0; ld_rd = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        chk_ra1 = 0; chk_ra2 = 0; chk_rd = 0;
        rf_rd1 = 0; rf_rd2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", {31'd0, rf_we}, 32'd0);
        check("rst_wa", {27'd0, rf_wa}, 32'd0);
        check("rst_wd", rf_wd, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_ready", {31'd0, lsu_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", {31'd0, lsu_ready}, 32'd0);
        tick();
        check("ready_after_edge", {31'd0, lsu_ready}, 32'd1);

        // Reset mid-burst: two queued loads, busy[5] set.
        ld_issue = 1; ld_rd = 5; tick();
        ld_issue = 0;
        alu_valid = 1; alu_rd = 1; alu_data = 32'h1111_0001;
        lsu_valid = 1; lsu_rd = 5; lsu_data = 32'h5555_0005; tick();
        lsu_rd = 6; lsu_data = 32'h6666_0006; tick();
        lsu_valid = 0;
        check("burst_full_ready", {31'd0, lsu_ready}, 32'd0);
        check("burst_busy5", {31'd0, busy[5]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we", {31'd0, rf_we}, 32'd0);
        check("midrst_wa", {27'd0, rf_wa}, 32'd0);
        check("midrst_wd", rf_wd, 32'd0);
        check("midrst_busy", busy, 32'd0);
        check("midrst_ready", {31'd0, lsu_ready}, 32'd0);
        model_reset();
        alu_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_no_we", {31'd0, rf_we}, 32'd0);
        end

        // ALU write and x0 write.
        alu_valid = 1; alu_rd = 3; alu_data = 32'hDEAD_BEEF; tick();
        check("alu_we", {31'd0, rf_we}, 32'd1);
        check("alu_wa", {27'd0, rf_wa}, 32'd3);
        check("alu_wd", rf_wd, 32'hDEAD_BEEF);
        alu_valid = 0; tick();
        check("alu_one_cycle", {31'd0, rf_we}, 32'd0);
        alu_valid = 1; alu_rd = 0; alu_data = 32'h0BAD_0BAD; tick();
        check("alu_x0", {31'd0, rf_we}, 32'd0);
        alu_valid = 0;

        // Load to x7 with decode watching it.
        chk_ra1 = 7;
        ld_issue = 1; ld_rd = 7; tick();
        ld_issue = 0;
        check("ld_busy7", {31'd0, busy[7]}, 32'd1);
        check("ld_stall", {31'd0, stall}, 32'd1);
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h0000_1234; tick();
        lsu_valid = 0;
        check("ld_no_fallthrough", {31'd0, rf_we}, 32'd0);
        check("ld_stall_q", {31'd0, stall}, 32'd1);
        tick();
        check("ld_we", {31'd0, rf_we}, 32'd1);
        check("ld_wa", {27'd0, rf_wa}, 32'd7);
        check("ld_wd", rf_wd, 32'h0000_1234);
        check("ld_busy7_clr", {31'd0, busy[7]}, 32'd0);
        tick();
        chk_ra1 = 0;

        // Back-pressure: ALU every cycle for 6 cycles, 3 LSU results offered.
        for (int i = 0; i < 3; i++) begin
            ld_issue = 1; ld_rd = 5'(20 + i); tick();
        end
        ld_issue = 0;
        for (int i = 0; i < 3; i++) d4[i] = $urandom;
        idx = 0;
        accepted_in_alu = 0;
        for (int c = 0; c < 24 && !(idx == 3 && mq.size() == 0); c++) begin
            alu_valid = (c < 6);
            alu_rd = 5'(10 + c);
            alu_data = $urandom;
            lsu_valid = (idx < 3);
            lsu_rd = 5'(20 + idx);
            lsu_data = (idx < 3) ? d4[idx] : 32'd0;
            tick();
            if (m_acc) idx++;
            if (c == 5) begin
                accepted_in_alu = idx;
                check("bp_ready_low", {31'd0, lsu_ready}, 32'd0);
            end
        end
        alu_valid = 0; lsu_valid = 0;
        check("bp_accepted_under_alu", accepted_in_alu, 2);
        check("bp_all_accepted", idx, 3);
        check("bp_drained", mq.size(), 0);
        tick();

        // Set/clear collision on x9.
        ld_issue = 1; ld_rd = 9; tick();
        ld_issue = 0;
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h9999_0009; tick();
        lsu_valid = 0;
        ld_issue = 1; ld_rd = 9; tick();
        ld_issue = 0;
        check("collide_busy9", {31'd0, busy[9]}, 32'd1);
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h9999_0019; tick();
        lsu_valid = 0;
        tick();
        tick();
        check("collide_busy9_clr", {31'd0, busy[9]}, 32'd0);

        // Bypass of the uncommitted write.
        chk_ra1 = 0; chk_ra2 = 4; chk_rd = 0; rf_rd2 = 32'd0; rf_rd1 = 32'h0101_0101;
        alu_valid = 1; alu_rd = 4; alu_data = 32'hA5A5_A5A5; tick();
        alu_valid = 0;
`ifdef WB_BYPASS_EN
        check("byp_rd2_fwd", byp_rd2, 32'hA5A5_A5A5);
        check("byp_stall", {31'd0, stall}, 32'd0);
`else
        check("byp_rd2_pass", byp_rd2, 32'd0);
        check("byp_stall", {31'd0, stall}, 32'd1);
`endif
        tick();

        // Randomized traffic with legal load issue.
        cur_valid = 0; cur_rd = 0; cur_data = 0;
        for (int c = 0; c < 400; c++) begin
            alu_valid = ($urandom_range(0, 9) < 6);
            alu_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            alu_data = $urandom;
            ld_issue = 0;
            if ($urandom_range(0, 3) == 0) begin
                ld_rd = 5'($urandom_range(0, 31));
                if (ld_rd == 5'd0 || !m_busy[ld_rd]) begin
                    ld_issue = 1;
                    pending.push_back(ld_rd);
                end
            end
            if (!cur_valid && pending.size() > 0 && $urandom_range(0, 1) == 1) begin
                cur_valid = 1;
                cur_rd = pending.pop_front();
                cur_data = $urandom;
            end
            lsu_valid = cur_valid; lsu_rd = cur_rd; lsu_data = cur_data;
            chk_ra1 = 5'($urandom_range(0, 31));
            chk_ra2 = 5'($urandom_range(0, 31));
            chk_rd = 5'($urandom_range(0, 31));
            rf_rd1 = $urandom; rf_rd2 = $urandom;
            tick();
            if (m_acc) cur_valid = 0;
        end

        // Drain every outstanding load.
        alu_valid = 0; ld_issue = 0;
        for (int c = 0; c < 200 && (cur_valid || pending.size() > 0 || mq.size() > 0); c++) begin
            if (!cur_valid && pending.size() > 0) begin
                cur_valid = 1;
                cur_rd = pending.pop_front();
                cur_data = $urandom;
            end
            lsu_valid = cur_valid; lsu_rd = cur_rd; lsu_data = cur_data;
            tick();
            if (m_acc) cur_valid = 0;
        end
        lsu_valid = 0;
        check("drain_done", {31'd0, cur_valid} + 32'(pending.size()) + 32'(mq.size()), 32'd0);
        tick();
        check("final_busy", busy, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
